// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and phase indices for the three-phase PWM path
package pwm_pkg;

    localparam int DEF_IN_WIDTH  = 12;
    localparam int DEF_PERIOD    = 3000;
    localparam int DEF_DEAD_TIME = 20;
    localparam int DEF_CNT_WIDTH = 12;

    // Phase positions in the {u, v, w} compare triple and gate vectors.
    localparam int U = 2;
    localparam int V = 1;
    localparam int W = 0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/dead_time_inserter.sv
// rtl/dead_time_inserter.sv - per-phase dead-time counter and complementary gate registers
module dead_time_inserter
    import pwm_pkg::*;
#(
    parameter int DEAD_TIME = DEF_DEAD_TIME
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    input  logic raw_d_i,
    input  logic raw_q_i,
    output logic pwm_h_o,
    output logic pwm_l_o
);

    localparam int DT_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEAD_TIME);

    logic [DT_W-1:0] dt_q, dt_d;
    logic            pwm_h_d, pwm_l_d;
    logic            settled;

    // dt restarts on the same edge that updates the raw signal, so it reads 0
    // in the first cycle the new raw level is visible.
    always_comb begin
        settled = (dt_q == DT_MAX);
        dt_d    = dt_q;
        if (!enable_i || (raw_d_i != raw_q_i)) begin
            dt_d = '0;
        end else if (!settled) begin
            dt_d = dt_q + DT_W'(1);
        end
        pwm_h_d = enable_i &  raw_q_i & settled;
        pwm_l_d = enable_i & ~raw_q_i & settled;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dt_q    <= '0;
            pwm_h_o <= 1'b0;
            pwm_l_o <= 1'b0;
        end else begin
            dt_q    <= dt_d;
            pwm_h_o <= pwm_h_d;
            pwm_l_o <= pwm_l_d;
        end
    end

endmodule

// File: rtl/pwm_generator_3ph.sv
// rtl/pwm_generator_3ph.sv - center-aligned three-phase PWM with double-buffered compares and dead time
module pwm_generator_3ph
    import pwm_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int DEAD_TIME = DEF_DEAD_TIME,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3*IN_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    output logic [2:0]            pwm_h,
    output logic [2:0]            pwm_l,
    output logic                  sync,
    output logic                  underrun
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(PERIOD - 1);
    localparam cnt_t CMP_MID = cnt_t'(PERIOD / 2);
    localparam cnt_t CMP_TOP = cnt_t'(PERIOD);

    cnt_t                      cnt_q, cnt_d;
    dir_e                      dir_q, dir_d;
    logic [2:0][CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [2:0][CNT_WIDTH-1:0] active_q, active_d;
    logic [2:0][CNT_WIDTH-1:0] cmp_in;
    logic                      full_q, full_d;
    logic                      in_ready_q, in_ready_d;
    logic [2:0]                p_q, p_d;
    logic                      sync_q, sync_d;
    logic                      underrun_q, underrun_d;
    logic                      period_end;
    logic                      xfer;

    function automatic cnt_t clamp(input logic [IN_WIDTH-1:0] v);
        if (int'(v) > PERIOD) begin
            return CMP_TOP;
        end
        return cnt_t'(v);
    endfunction

    always_comb begin
        period_end = (cnt_q == '0) && (dir_q == DIR_DOWN);
        xfer       = in_valid && in_ready_q;

        cmp_in    = '0;
        cmp_in[U] = clamp(in_data[U*IN_WIDTH +: IN_WIDTH]);
        cmp_in[V] = clamp(in_data[V*IN_WIDTH +: IN_WIDTH]);
        cmp_in[W] = clamp(in_data[W*IN_WIDTH +: IN_WIDTH]);

        // Triangle carrier: each turning value is held for one extra cycle.
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_MAX) dir_d = DIR_DOWN;
            else                  cnt_d = cnt_q + cnt_t'(1);
        end else begin
            if (cnt_q == '0) dir_d = DIR_UP;
            else             cnt_d = cnt_q - cnt_t'(1);
        end

        shadow_d   = shadow_q;
        full_d     = full_q;
        active_d   = active_q;
        underrun_d = 1'b0;
        if (period_end) begin
            full_d = 1'b0;
            if (xfer)        active_d   = cmp_in;
            else if (full_q) active_d   = shadow_q;
            else             underrun_d = 1'b1;
        end else if (xfer) begin
            shadow_d = cmp_in;
            full_d   = 1'b1;
        end
        in_ready_d = !full_d;
        sync_d     = period_end;

        for (int i = 0; i < 3; i++) begin
            p_d[i] = (cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            shadow_q   <= '0;
            full_q     <= 1'b0;
            active_q   <= {3{CMP_MID}};
            in_ready_q <= 1'b0;
            p_q        <= '0;
            sync_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            shadow_q   <= shadow_d;
            full_q     <= full_d;
            active_q   <= active_d;
            in_ready_q <= in_ready_d;
            p_q        <= p_d;
            sync_q     <= sync_d;
            underrun_q <= underrun_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_dt
        dead_time_inserter #(
            .DEAD_TIME (DEAD_TIME)
        ) u_dt (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable_i (enable),
            .raw_d_i  (p_d[i]),
            .raw_q_i  (p_q[i]),
            .pwm_h_o  (pwm_h[i]),
            .pwm_l_o  (pwm_l[i])
        );
    end

    assign in_ready = in_ready_q;
    assign sync     = sync_q;
    assign underrun = underrun_q;

endmodule
